// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// Decode fields and memory status in, enables and mux selects out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        input  IllegalOp, State
    );

    modport slave (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        output IllegalOp, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM over a shared instruction/data memory.
// Moore outputs per state, with MemReady stalls in FETCH/MEMREAD/MEMWRITE.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.slave        bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_e     state_q, state_d;
    logic       pc_w, adr, mem_w, ir_w, reg_w, ill;
    logic [1:0] res_s, src_a, src_b, imm_s;
    logic [2:0] alu_c, alu_fn;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        alu_fn = 3'b000;
        case (bus.funct3)
            3'b000:  alu_fn = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_fn = 3'b101;
            3'b110:  alu_fn = 3'b011;
            3'b111:  alu_fn = 3'b010;
            default: alu_fn = 3'b000;
        endcase
    end

    always_comb begin
        imm_s = 2'b00;
        case (bus.op)
            OP_SW:   imm_s = 2'b01;
            OP_BEQ:  imm_s = 2'b10;
            OP_JAL:  imm_s = 2'b11;
            default: imm_s = 2'b00;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        pc_w    = 1'b0;
        adr     = 1'b0;
        mem_w   = 1'b0;
        ir_w    = 1'b0;
        reg_w   = 1'b0;
        ill     = 1'b0;
        res_s   = 2'b00;
        src_a   = 2'b00;
        src_b   = 2'b00;
        alu_c   = 3'b000;
        case (state_q)
            FETCH: begin
                src_b   = 2'b10;
                res_s   = 2'b10;
                ir_w    = bus.MemReady;
                pc_w    = bus.MemReady;
                state_d = bus.MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        state_d = FETCH;
                        ill     = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr     = 1'b1;
                state_d = bus.MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                res_s = 2'b01;
                reg_w = 1'b1;
            end
            MEMWRITE: begin
                adr     = 1'b1;
                mem_w   = 1'b1;
                state_d = bus.MemReady ? FETCH : MEMWRITE;
            end
            EXECR: begin
                src_a   = 2'b10;
                alu_c   = alu_fn;
                state_d = ALUWB;
            end
            EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_c   = alu_fn;
                state_d = ALUWB;
            end
            JAL: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                pc_w    = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BEQ: begin
                src_a = 2'b10;
                alu_c = 3'b001;
                pc_w  = bus.Zero;
            end
            default: state_d = FETCH;
        endcase
        // Reset overrides every enable so a half-done store cannot commit
        if (reset) begin
            pc_w  = 1'b0;
            mem_w = 1'b0;
            ir_w  = 1'b0;
            reg_w = 1'b0;
            ill   = 1'b0;
        end
    end

    assign bus.PCWrite    = pc_w;
    assign bus.AdrSrc     = adr;
    assign bus.MemWrite   = mem_w;
    assign bus.IRWrite    = ir_w;
    assign bus.RegWrite   = reg_w;
    assign bus.ResultSrc  = res_s;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = imm_s;
    assign bus.ALUControl = alu_c;
    assign bus.IllegalOp  = ill;
    assign bus.State      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus a random
// instruction stream checked against a per-instruction step model.
module tb_multicycle_controller;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == SW)  return 2'b01;
        if (op == BQ)  return 2'b10;
        if (op == JL)  return 2'b11;
        return 2'b00;
    endfunction

    // add=0 sub=1 and=2 or=3 slt=5, from the instruction's meaning
    function automatic logic [2:0] alu_ref(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'd0: return (op == RT && f7) ? 3'd1 : 3'd0;
            3'd2: return 3'd5;
            3'd6: return 3'd3;
            3'd7: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT ||
               op == IT || op == JL || op == BQ;
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z,
                             input int fs, input int ms, input string tag);
        int es[$];
        bit mr[$];
        int rw = 0, mw = 0, pw = 0, iw = 0, il = 0;
        int erw, emw, epw;
        for (int i = 0; i < fs; i++) begin es.push_back(0); mr.push_back(0); end
        es.push_back(0); mr.push_back(1);
        es.push_back(1); mr.push_back($urandom_range(0, 1));
        if (op == LW || op == SW) begin
            es.push_back(2); mr.push_back($urandom_range(0, 1));
            for (int i = 0; i < ms; i++) begin
                es.push_back(op == LW ? 3 : 5); mr.push_back(0);
            end
            es.push_back(op == LW ? 3 : 5); mr.push_back(1);
            if (op == LW) begin es.push_back(4); mr.push_back($urandom_range(0, 1)); end
        end else if (op == RT || op == IT || op == JL) begin
            es.push_back(op == RT ? 6 : (op == IT ? 8 : 9));
            mr.push_back($urandom_range(0, 1));
            es.push_back(7); mr.push_back($urandom_range(0, 1));
        end else if (op == BQ) begin
            es.push_back(10); mr.push_back($urandom_range(0, 1));
        end
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        for (int k = 0; k < es.size(); k++) begin
            bus.MemReady = mr[k];
            #1;
            total++;
            if (bus.State !== 4'(es[k])) begin
                bad++;
                $display("FAIL %s state step %0d: got %0d want %0d", tag, k, bus.State, es[k]);
            end
            total++;
            if (bus.ImmSrc !== imm_ref(op)) begin
                bad++;
                $display("FAIL %s ImmSrc: got %b want %b", tag, bus.ImmSrc, imm_ref(op));
            end
            if (es[k] == 6 || es[k] == 8) begin
                total++;
                if (bus.ALUControl !== alu_ref(op, f3, f7)) begin
                    bad++;
                    $display("FAIL %s ALUControl: got %b want %b", tag,
                             bus.ALUControl, alu_ref(op, f3, f7));
                end
            end
            if (bus.RegWrite === 1'b1) begin
                total++;
                if (bus.ResultSrc !== (op == LW ? 2'b01 : 2'b00)) begin
                    bad++;
                    $display("FAIL %s ResultSrc on write: got %b", tag, bus.ResultSrc);
                end
            end
            rw += int'(bus.RegWrite === 1'b1);
            mw += int'(bus.MemWrite === 1'b1);
            pw += int'(bus.PCWrite === 1'b1);
            iw += int'(bus.IRWrite === 1'b1);
            il += int'(bus.IllegalOp === 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        erw = (op == LW || op == RT || op == IT || op == JL) ? 1 : 0;
        emw = (op == SW) ? ms + 1 : 0;
        epw = 1 + ((op == JL) ? 1 : 0) + ((op == BQ && z) ? 1 : 0);
        total++;
        if (rw !== erw) begin bad++; $display("FAIL %s RegWrite cycles: got %0d want %0d", tag, rw, erw); end
        total++;
        if (mw !== emw) begin bad++; $display("FAIL %s MemWrite cycles: got %0d want %0d", tag, mw, emw); end
        total++;
        if (pw !== epw) begin bad++; $display("FAIL %s PCWrite cycles: got %0d want %0d", tag, pw, epw); end
        total++;
        if (iw !== 1) begin bad++; $display("FAIL %s IRWrite cycles: got %0d want 1", tag, iw); end
        total++;
        if (il !== (legal(op) ? 0 : 1)) begin
            bad++;
            $display("FAIL %s IllegalOp cycles: got %0d want %0d", tag, il, legal(op) ? 0 : 1);
        end
        #1;
        total++;
        if (bus.State !== 4'd0) begin bad++; $display("FAIL %s end state: got %0d want 0", tag, bus.State); end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.MemReady = 1'b1; bus.op = SW;
        bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        @(negedge clk); #1;
        total++;
        if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
            bad++; $display("FAIL reset enables: IRWrite=%b PCWrite=%b want 0", bus.IRWrite, bus.PCWrite);
        end
        total++;
        if (bus.State !== 4'd0) begin bad++; $display("FAIL reset state: got %0d want 0", bus.State); end
        @(negedge clk);
        reset = 1'b0; #1;
        total++;
        if (bus.IRWrite !== 1'b1) begin bad++; $display("FAIL first fetch IRWrite: got %b want 1", bus.IRWrite); end
        repeat (3) @(negedge clk);
        bus.MemReady = 1'b0; #1;
        total++;
        if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin
            bad++; $display("FAIL reach memwrite: state=%0d MemWrite=%b want 5/1", bus.State, bus.MemWrite);
        end
        reset = 1'b1; #1;
        total++;
        if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL reset in memwrite: MemWrite=%b want 0", bus.MemWrite); end
        @(negedge clk); #1;
        total++;
        if (bus.State !== 4'd0) begin bad++; $display("FAIL reset from memwrite: state=%0d want 0", bus.State); end
        reset = 1'b0; bus.MemReady = 1'b1; #1;
        total++;
        if (bus.IRWrite !== 1'b1) begin bad++; $display("FAIL fetch after reset: IRWrite=%b want 1", bus.IRWrite); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 0, "lw");
    endtask

    task automatic test_sw_stall();
        run_instr(SW, 3'd2, 1'b0, 1'b0, 0, 2, "sw_stall");
    endtask

    task automatic test_alu_decode();
        run_instr(RT, 3'd0, 1'b1, 1'b0, 0, 0, "r_sub");
        run_instr(IT, 3'd0, 1'b1, 1'b0, 0, 0, "addi");
        run_instr(RT, 3'd7, 1'b0, 1'b0, 1, 0, "r_and");
        run_instr(IT, 3'd2, 1'b0, 1'b0, 0, 0, "slti");
    endtask

    task automatic test_beq();
        run_instr(BQ, 3'd0, 1'b0, 1'b1, 0, 0, "beq_taken");
        run_instr(BQ, 3'd0, 1'b0, 1'b0, 0, 0, "beq_not");
    endtask

    task automatic test_illegal();
        run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0, "illegal");
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = JL; ops[5] = BQ;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                if (legal(op)) op = 7'b1111111;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_alu_decode();
        test_beq();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
